// File: rtl/gcd_datapath_if.sv
// Host/controller bundle for the subtractive GCD datapath.
// master = host + gcd_controller side, slave = gcd_datapath.
interface gcd_datapath_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [1:0]       edit_num;
    logic             get_res;
    logic [1:0]       compare;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;

    modport master (
        output start, a_in, b_in, edit_num, get_res,
        input  compare, result, done, busy
    );

    modport slave (
        input  start, a_in, b_in, edit_num, get_res,
        output compare, result, done, busy
    );
endinterface

// File: rtl/gcd_datapath.sv
// Operand registers, compare code and result latch of the subtractive GCD unit.
// Sequencing (which subtract, when to finish) comes from gcd_controller.
module gcd_datapath #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    gcd_datapath_if.slave bus
);
    typedef enum logic [1:0] {
        EDIT_HOLD = 2'd0,
        EDIT_A    = 2'd1,
        EDIT_B    = 2'd2,
        EDIT_RSVD = 2'd3
    } edit_e;

    typedef enum logic [1:0] {
        CMP_IDLE = 2'd0,
        CMP_EQ   = 2'd1,
        CMP_AGT  = 2'd2,
        CMP_BGT  = 2'd3
    } cmp_e;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load, latch;
    cmp_e             cmp;

    assign load  = bus.start & ~busy_q;
    assign latch = bus.get_res & busy_q;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        res_d  = res_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (load) begin
            busy_d = 1'b1;
            // A zero operand is replaced by the other one so the loop always ends.
            if (bus.a_in == '0) begin
                a_d = bus.b_in;
                b_d = bus.b_in;
            end else if (bus.b_in == '0) begin
                a_d = bus.a_in;
                b_d = bus.a_in;
            end else begin
                a_d = bus.a_in;
                b_d = bus.b_in;
            end
        end else if (latch) begin
            // get_res beats a simultaneous subtract command.
            res_d  = a_q;
            done_d = 1'b1;
            busy_d = 1'b0;
        end else if (busy_q) begin
            case (edit_e'(bus.edit_num))
                EDIT_A:  a_d = a_q - b_q;
                EDIT_B:  b_d = b_q - a_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        cmp = CMP_IDLE;
        if (busy_q) begin
            if (a_q == b_q)     cmp = CMP_EQ;
            else if (a_q > b_q) cmp = CMP_AGT;
            else                cmp = CMP_BGT;
        end
    end

    assign bus.compare = cmp;
    assign bus.result  = res_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_gcd_datapath.sv
// Bench for gcd_datapath: a behavioural controller drives edit_num/get_res,
// a reference model tracks A/B, and finished results go through a scoreboard.
module tb_gcd_datapath;
    localparam int W = 8;

    typedef enum int {S_EQ, S_GT, S_EDIT, S_RES} cst_e;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    logic [W-1:0] exp_q[$];

    gcd_datapath_if #(.WIDTH(W)) bus ();
    gcd_datapath #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] cmp_of(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == b) return 2'd1;
        if (a > b)  return 2'd2;
        return 2'd3;
    endfunction

    // scoreboard consumer
    initial begin
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) chk("spurious_done", 1, 0);
                else chk("result", bus.result, exp_q.pop_front());
                chk("busy_at_done", bus.busy, 0);
            end
        end
    end

    // One GCD run with a behavioural controller. inj: cycle to pulse a stray
    // start (5,3); abort_at: cycle to assert async reset mid-run (-1 = none).
    task automatic run_gcd(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp, input int inj, input int abort_at);
        logic [W-1:0] ma, mb;
        logic [1:0]   dir;
        cst_e         st, st_n;
        bit           fin;
        int           base;
        if (a == 0 && b != 0)      begin ma = b; mb = b; end
        else if (b == 0 && a != 0) begin ma = a; mb = a; end
        else                       begin ma = a; mb = b; end
        dir = 2'd0;
        @(negedge clk);
        bus.start = 1'b1; bus.a_in = a; bus.b_in = b;
        exp_q.push_back(exp);
        base = done_cnt;
        @(posedge clk);
        st = S_EQ; fin = 1'b0;
        for (int c = 0; c < 2000 && !fin; c++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.edit_num = 2'd0; bus.get_res = 1'b0;
            if (c == inj) begin
                bus.start = 1'b1; bus.a_in = 8'd5; bus.b_in = 8'd3;
            end
            if (c == abort_at) begin
                #1 rst = 1'b0;
                #1;
                chk("rst_busy", bus.busy, 0);
                chk("rst_cmp", bus.compare, 0);
                chk("rst_done", bus.done, 0);
                chk("rst_a", dut.a_q, 0);
                chk("rst_b", dut.b_q, 0);
                void'(exp_q.pop_back());
                @(negedge clk) rst = 1'b1;
                repeat (4) @(negedge clk);
                chk("abort_no_done", done_cnt - base, 0);
                return;
            end
            chk("busy_run", bus.busy, 1);
            st_n = st;
            case (st)
                S_EQ: begin
                    chk("cmp_eq_state", bus.compare, cmp_of(ma, mb));
                    st_n = (ma == mb) ? S_RES : S_GT;
                end
                S_GT: begin
                    chk("cmp_gt_state", bus.compare, cmp_of(ma, mb));
                    dir  = (ma > mb) ? 2'd1 : 2'd2;
                    st_n = S_EDIT;
                end
                S_EDIT: begin
                    bus.edit_num = dir;
                    if (dir == 2'd1) ma = ma - mb;
                    else             mb = mb - ma;
                    st_n = S_EQ;
                end
                S_RES: begin
                    bus.get_res = 1'b1;
                    fin = 1'b1;
                end
                default: ;
            endcase
            @(posedge clk);
            st = st_n;
        end
        if (!fin) chk("timeout", 0, 1);
        @(negedge clk);
        bus.get_res = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt - base, 1);
        chk("idle_cmp", bus.compare, 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.a_in = '0; bus.b_in = '0;
        bus.edit_num = 2'd0; bus.get_res = 1'b0;
        #12;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_result", bus.result, 0);
        chk("reset_cmp", bus.compare, 0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);

        // get_res / edit_num while idle must do nothing
        bus.get_res = 1'b1; bus.edit_num = 2'd1;
        @(negedge clk);
        bus.get_res = 1'b0; bus.edit_num = 2'd0;
        chk("idle_getres_done", bus.done, 0);
        chk("idle_getres_busy", bus.busy, 0);
        chk("idle_getres_result", bus.result, 0);

        run_gcd(8'd12,  8'd8,  8'd4,   -1, -1);
        run_gcd(8'd7,   8'd7,  8'd7,   -1, -1);
        run_gcd(8'd0,   8'd9,  8'd9,   -1, -1);
        run_gcd(8'd0,   8'd0,  8'd0,   -1, -1);
        run_gcd(8'd10,  8'd0,  8'd10,  -1, -1);
        run_gcd(8'd255, 8'd1,  8'd1,   -1, -1);
        run_gcd(8'd12,  8'd8,  8'd4,    2, -1);
        run_gcd(8'd200, 8'd75, 8'd25,  -1, -1);
        chk("result_hold", bus.result, 25);
        run_gcd(8'd12,  8'd8,  8'd4,   -1,  3);
        chk("result_after_abort", bus.result, 0);
        run_gcd(8'd9,   8'd6,  8'd3,   -1, -1);
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/gcd_datapath.md
Name: gcd_datapath

Overview:
- Operand/arithmetic half of the subtractive GCD unit. Pairs with gcd_controller.
- Holds operands A and B and produces the 2-bit compare code that the controller consumes.
- Applies the controller's edit_num subtract commands and latches the final result on get_res.
- Sits between the host (operands, start, result, done) and gcd_controller (compare out; edit_num and get_res in).

Parameters:
- WIDTH, 8, operand and result width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- start  input  1  host load request; also wired to the controller's start.
- a_in  input  WIDTH  operand A, sampled on a load.
- b_in  input  WIDTH  operand B, sampled on a load.
- edit_num  input  2  controller command: 0 = hold, 1 = A <= A-B, 2 = B <= B-A, 3 = ignored (hold).
- get_res  input  1  controller strobe: latch the result.
- compare  output  2  0 = idle/invalid, 1 = A==B, 2 = A>B, 3 = B>A.
- result  output  WIDTH  last GCD, registered.
- done  output  1  one-cycle pulse when result updates.
- busy  output  1  high from load until the result is latched.

Behaviour:
- Reset (rst=0, asynchronous): A=0, B=0, busy=0, done=0, result=0, compare=0. Effect is immediate, independent of clk, and aborts any computation in progress. No result or done pulse is produced for an aborted run.
- Load: at a rising edge with start=1 and busy=0:
  - A<=a_in, B<=b_in, busy<=1.
  - Zero fix-up, so the subtract loop always terminates:
    - a_in=0 and b_in!=0: A<=b_in, B<=b_in.
    - b_in=0 and a_in!=0: A<=a_in, B<=a_in.
    - Both 0: A=B=0, giving result 0.
  - Load happens on the same edge the controller leaves wait_start, so compare is valid when the controller enters check_equal.
- start while busy=1 is ignored; the operands are not disturbed.
- compare is combinational from the registered A, B and busy:
  - busy=0 forces 0.
  - Otherwise 1 if A==B, 2 if A>B, 3 if A<B.
  - Unsigned comparison.
- Subtract: at a rising edge with busy=1:
  - edit_num=1: A<=A-B.
  - edit_num=2: B<=B-A.
  - edit_num=0 or 3: no change.
  - Arithmetic is WIDTH-bit unsigned. Underflow cannot occur under a legal command sequence. The block performs no check and the result wraps modulo 2^WIDTH.
  - edit_num is ignored while busy=0.
- Result: at a rising edge with get_res=1 and busy=1:
  - result<=A, done<=1 for exactly the next cycle, busy<=0.
  - get_res with busy=0 has no effect.
- get_res and a nonzero edit_num in the same cycle (illegal from the controller): get_res wins and the subtract is dropped.
- result holds its value until the next successful get_res or reset.
- Latency from the start edge to done is 2 + 3·(number of subtract steps) + 1 cycles. One subtract step spans check_equal, check_greater and the edit state. Example: gcd(12,8) takes 2 steps, so done asserts in cycle 9 after the start edge.
- done is never asserted outside the cycle following a get_res.

Test Plan:
- Reset, then start with a_in=12, b_in=8, run with gcd_controller: compare sequence 2, 3, 1. Required: result=4, done high for 1 cycle, busy drops with done.
- a_in=7, b_in=7: compare=1 on the first cycle after load. Required: result=7, no edit_num activity, done pulses.
- a_in=0, b_in=9: A=B=9 after load, compare=1. Required: result=9. Also a_in=0, b_in=0: required result=0, done pulses.
- WIDTH=8, a_in=255, b_in=1: 254 subtract steps. Required: result=1, busy held for the whole run, done exactly once.
- Start with 12 and 8, then pulse start again with a_in=5, b_in=3 mid-run. Required: the second start is ignored and result=4.
- Start with 12 and 8, drive rst=0 asynchronously between clock edges mid-run. Required: A, B, busy, compare go to 0 immediately and no done pulse. After release, start with 9 and 6: required result=3.
